pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on both sides. Operands are split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers the carry into the next stage, so throughput is one operation per clock at any width. The block is the general arithmetic datapath unit for wide adds in the arithmetic family, replacing fixed-width combinational adders wherever timing or backpressure matters.

## Interface
- WIDTH, 16: operand/result width in bits; ≥2.
- STAGES, 4: pipeline depth; ≥1; WIDTH % STAGES == 0 (elaboration error otherwise). CHUNK = WIDTH/STAGES.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of MSB (in sub mode 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Effective B = sub ? ~b : b. Effective carry-in = sub ? ~cin : cin.
- Stage k (0-based) adds chunk k of A and effective B plus the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Operand chunks above k are skew-delayed until stage k consumes them. Result chunks below k are carried forward so that all of sum emerges aligned.
- cout = carry out of bit WIDTH−1. ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Each stage holds a valid bit. Empty stages are bubbles and carry no result.
- Global stall: advance = !out_valid || out_ready. in_ready = advance. When advance = 0, all stage registers and valid bits hold.
- A beat is accepted when in_valid && in_ready. If in_valid = 0 while advancing, a bubble enters stage 0.
- Results leave in acceptance order. No reordering, no drops, no duplicates.

## Timing
- Reset (async assert, released synchronously to clk by the integrator): all valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. in_ready = 1 immediately after reset.
- Latency: if a beat is accepted on edge t, out_valid = 1 with its result after edge t+STAGES−1, given no stalls. STAGES = 1 gives a single registered adder.
- Throughput: one beat per cycle while out_ready stays 1.
- While out_valid && !out_ready: sum/cout/ovf/out_valid are stable, in_ready = 0, and upstream beats wait.
- A beat can be accepted on the same edge that the output beat is consumed, because in_ready depends combinationally on out_ready.
- in_ready does not depend on in_valid.
- Reset mid-operation discards all in-flight beats. No partial result is ever presented.
- Inputs a/b/cin/sub are sampled only on the accepting edge. They may change freely otherwise.

## Configuration
- PIPE_ADDER_SAT_EN defined: on ovf = 1, sum is clamped to the signed extreme in the direction of the true result. A true result above the maximum gives 0111…1. A true result below the minimum gives 1000…0. ovf and cout still report the raw values. Clamping is applied in the final stage with no added latency.
- Undefined: sum wraps modulo 2^WIDTH. No saturation logic is present.

## Test plan
- WIDTH=16, STAGES=4, a=0x00FF, b=0x0001, cin=0, sub=0 → after 4 edges: sum=0x0100, cout=0, ovf=0. Carry crosses the chunk 1→2 boundary.
- a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000 (0x7FFF with PIPE_ADDER_SAT_EN), cout=0, ovf=1.
- sub=1: a=0x0005, b=0x0003, cin=0 → sum=0x0002, cout=1. a=0x0003, b=0x0005, cin=1 → sum=0xFFFD, cout=0, ovf=0. a=0x8000, b=0x0001, cin=0 → sum=0x7FFF (0x8000 with SAT), ovf=1.
- Backpressure: stream 8 beats (a=i, b=i·0x1111, where i is the beat index 0..7) with out_ready toggled pseudo-randomly. Expected: all 8 results appear in order, values and handshakes match a reference model, and output stays stable during stalls with in_ready=0.
- Back-to-back with out_ready=1: 10 consecutive beats → 10 consecutive out_valid cycles, the first after edge t+3.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle before any emerge. Expected: out_valid=0 immediately, no stale result appears afterwards, and the next accepted beat computes correctly.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK per stage, valid/ready on both sides.
// Define PIPE_ADDER_SAT_EN to clamp sum to the signed extreme on overflow.
module pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : 1;

   if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_err
      $error("pipe_adder: WIDTH must be >=2 and a multiple of STAGES>=1");
   end

   logic [WIDTH-1:0] a_q  [STAGES];
   logic [WIDTH-1:0] b_q  [STAGES];
   logic [WIDTH-1:0] s_q  [STAGES];
   logic             c_q  [STAGES];
   logic             v_q  [STAGES];
   logic             ovf_q;

   logic [WIDTH-1:0] op_a [STAGES];
   logic [WIDTH-1:0] op_b [STAGES];
   logic [WIDTH-1:0] op_s [STAGES];
   logic             op_c [STAGES];
   logic             op_v [STAGES];
   logic [CHUNK:0]   part [STAGES];
   logic [WIDTH-1:0] s_d  [STAGES];
   logic             c_d  [STAGES];
   logic             ovf_d;
   logic             msb_cin;
   logic             advance;

   // Stage 0 sees the ports; later stages see the previous stage's registers.
   always_comb begin
      advance = !v_q[STAGES-1] || out_ready;
      op_a[0] = a;
      op_b[0] = sub ? ~b : b;
      op_c[0] = sub ^ cin;
      op_s[0] = '0;
      op_v[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         op_a[k] = a_q[k-1];
         op_b[k] = b_q[k-1];
         op_c[k] = c_q[k-1];
         op_s[k] = s_q[k-1];
         op_v[k] = v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part[k] = {1'b0, op_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, op_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, op_c[k]};
         s_d[k] = op_s[k];
         s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
         c_d[k] = part[k][CHUNK];
      end
      // Carry into the MSB recovered from the MSB sum bit.
      msb_cin = op_a[STAGES-1][WIDTH-1]
              ^ op_b[STAGES-1][WIDTH-1]
              ^ s_d[STAGES-1][WIDTH-1];
      ovf_d = msb_cin ^ c_d[STAGES-1];
`ifdef PIPE_ADDER_SAT_EN
      if (ovf_d) begin
         s_d[STAGES-1] = {~s_d[STAGES-1][WIDTH-1],
                          {(WIDTH-1){s_d[STAGES-1][WIDTH-1]}}};
      end
`else
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= op_v[k];
            if (op_v[k]) begin
               a_q[k] <= op_a[k];
               b_q[k] <= op_b[k];
               s_q[k] <= s_d[k];
               c_q[k] <= c_d[k];
            end
         end
         if (op_v[STAGES-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign in_ready  = advance;
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Randomized bench for pipe_adder against an integer-arithmetic model.
// Checks values, order, latency, stall stability and mid-flight reset.
module tb_pipe_adder;

   localparam int W = 16;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      int           t;
   } exp_t;

   exp_t         sb_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           widx = 0;
   bit           exact_lat = 1'b0;
   bit           pv_stall = 1'b0;
   logic [W-1:0] pv_sum;
   logic         pv_co;
   logic         pv_ov;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic su);
      exp_t e;
      int sx, sy, r;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (!su) begin
         r = sx + sy + int'(ci);
         e.co = (int'(x) + int'(y) + int'(ci)) > 65535;
      end else begin
         r = sx - sy - int'(ci);
         e.co = int'(x) >= (int'(y) + int'(ci));
      end
      e.ov = (r > 32767) || (r < -32768);
      e.s = r[W-1:0];
`ifdef PIPE_ADDER_SAT_EN
      if (e.ov) e.s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
      e.t = 0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] s, input logic co,
                               input logic ov);
      exp_t e;
      e.s = s;
      e.co = co;
      e.ov = ov;
      e.t = 0;
      return e;
   endfunction

   task automatic cyc(input logic v, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic ci, input logic su,
                      input logic ory, input bit use_exp, input exp_t ex,
                      output bit acc);
      exp_t e;
      exp_t h;
      @(negedge clk);
      in_valid = v;
      a = x;
      b = y;
      cin = ci;
      sub = su;
      out_ready = ory;
      #1;
      widx++;
      if (pv_stall) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_sum", 32'(sum), 32'(pv_sum));
         chk("stall_cout", 32'(cout), 32'(pv_co));
         chk("stall_ovf", 32'(ovf), 32'(pv_ov));
      end
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      acc = v && in_ready;
      if (acc) begin
         e = use_exp ? ex : model(x, y, ci, su);
         e.t = widx;
         sb_q.push_back(e);
      end
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
         end else begin
            h = sb_q.pop_front();
            chk("sum", 32'(sum), 32'(h.s));
            chk("cout", 32'(cout), 32'(h.co));
            chk("ovf", 32'(ovf), 32'(h.ov));
            if (exact_lat) chk("latency", 32'(widx - h.t), 32'(S));
         end
      end
      pv_stall = out_valid && !out_ready;
      pv_sum = sum;
      pv_co = cout;
      pv_ov = ovf;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic su, input bit rnd,
                       input bit use_exp, input exp_t ex);
      bit acc;
      int n;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         cyc(1'b1, x, y, ci, su, rnd ? 1'($urandom_range(0, 1)) : 1'b1,
             use_exp, ex, acc);
         n++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input bit rnd);
      bit   acc;
      int   n;
      exp_t nx;
      nx = mk('0, 1'b0, 1'b0);
      n = 0;
      while (sb_q.size() > 0 && n < 200) begin
         cyc(1'b0, '0, '0, 1'b0, 1'b0,
             rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, nx, acc);
         n++;
      end
      if (sb_q.size() > 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      exp_t nx;
      bit   acc;
      logic [W-1:0] sat_p;
      logic [W-1:0] sat_n;
      nx = mk('0, 1'b0, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
      sat_p = 16'h7FFF;
      sat_n = 16'h8000;
`else
      sat_p = 16'h8000;
      sat_n = 16'h7FFF;
`endif

      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      exact_lat = 1'b1;
      send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, mk(16'h0100, 1'b0, 1'b0));
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, mk(sat_p, 1'b0, 1'b1));
      send(16'h0005, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1, mk(16'h0002, 1'b1, 1'b0));
      send(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b1, mk(16'hFFFD, 1'b0, 1'b0));
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, mk(sat_n, 1'b1, 1'b1));
      drain(1'b0);

      exact_lat = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(16'(i), 16'(i * 32'h1111), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1, 1'b0, nx);
      end
      drain(1'b1);

      exact_lat = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, 1'b0, nx);
      end
      drain(1'b0);

      exact_lat = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, nx);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      sb_q.delete();
      pv_stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, nx, acc);
      end
      exact_lat = 1'b1;
      send(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 1'b1, mk(16'h5556, 1'b0, 1'b0));
      drain(1'b0);

      exact_lat = 1'b0;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, nx, acc);
         end
         send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1, 1'b0, nx);
      end
      drain(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
